// File: rtl/adma_arb_pkg.sv
// Shared types and helpers for the ADMA channel arbiter.
package adma_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Width of a channel id; never narrower than one bit.
    function automatic int chn_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Cyclic increment modulo n; n need not be a power of two.
    function automatic int cyc_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/adma_rr_pick.sv
// Rotating priority encoder: first set bit of elig at or after start,
// searching cyclically modulo N.
module adma_rr_pick
    import adma_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = chn_id_w(N)
) (
    input  logic [N-1:0]    elig,
    input  logic [ID_W-1:0] start,
    output logic [ID_W-1:0] win,
    output logic            any_vld
);

    // Walk offsets from farthest to nearest so the nearest eligible wins.
    always_comb begin
        win     = '0;
        any_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (elig[(int'(start) + i) % N]) begin
                win     = ID_W'((int'(start) + i) % N);
                any_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adma_chn_arb.sv
// Weighted round-robin arbiter sharing the AXI master datapath among DMA
// channels. One grant covers one burst; an owner keeps the datapath for up
// to rate+1 consecutive bursts while it keeps requesting.
// Optional watchdog: define ADMA_ARB_TIMEOUT_EN to release a grant that
// sees no burst_done_i for ARB_TIMEOUT busy cycles.
module adma_chn_arb
    import adma_arb_pkg::*;
#(
    parameter int DMA_CHN_NUM   = 4,
    parameter int DMA_CHN_ARB_W = 3,
    parameter int ARB_TIMEOUT   = 1024,
    localparam int CHN_ID_W     = chn_id_w(DMA_CHN_NUM)
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     dma_en_i,
    input  logic [DMA_CHN_NUM-1:0]   chn_en_i,
    input  logic [DMA_CHN_ARB_W-1:0] chn_arb_rate_i [0:DMA_CHN_NUM-1],
    input  logic [DMA_CHN_NUM-1:0]   req_vld_i,
    output logic [DMA_CHN_NUM-1:0]   req_rdy_o,
    output logic                     gnt_vld_o,
    output logic [CHN_ID_W-1:0]      gnt_chn_id_o,
    input  logic                     burst_done_i,
    output logic                     arb_timeout_o
);

    arb_state_t               state_reg;
    logic [CHN_ID_W-1:0]      rr_ptr_reg;
    logic [CHN_ID_W-1:0]      owner_reg;
    logic [DMA_CHN_ARB_W-1:0] cnt_reg;
    logic                     sticky_reg;
    logic                     gnt_vld_reg;
    logic [DMA_CHN_NUM-1:0]   req_rdy_reg;

    logic [DMA_CHN_NUM-1:0]   elig;
    logic [DMA_CHN_NUM-1:0]   rdy_onehot;
    logic [CHN_ID_W-1:0]      owner_next;
    logic [CHN_ID_W-1:0]      search_start;
    logic [CHN_ID_W-1:0]      pick_win;
    logic [CHN_ID_W-1:0]      grant_id;
    logic                     pick_any;
    logic                     sticky_hit;
    logic                     grant_any;

    genvar gi;
    generate
        for (gi = 0; gi < DMA_CHN_NUM; gi++) begin : g_chn
            assign elig[gi]       = dma_en_i & chn_en_i[gi] & req_vld_i[gi];
            assign rdy_onehot[gi] = (grant_id == CHN_ID_W'(gi));
        end
    endgenerate

    assign owner_next = CHN_ID_W'(cyc_inc(int'(owner_reg), DMA_CHN_NUM));
    // A sticky owner that still requests continues its turn without a search.
    assign sticky_hit   = sticky_reg & elig[owner_reg];
    // A sticky owner that stopped requesting forfeits: search resumes after it.
    assign search_start = sticky_reg ? owner_next : rr_ptr_reg;

    adma_rr_pick #(
        .N    (DMA_CHN_NUM),
        .ID_W (CHN_ID_W)
    ) u_pick (
        .elig    (elig),
        .start   (search_start),
        .win     (pick_win),
        .any_vld (pick_any)
    );

    assign grant_id  = sticky_hit ? owner_reg : pick_win;
    assign grant_any = sticky_hit | pick_any;

`ifdef ADMA_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(ARB_TIMEOUT + 1);
    logic [TO_W-1:0] busy_cnt_reg;
    logic            timeout_reg;
`endif

    // Arbiter FSM: grant in IDLE, hold ownership in BUSY until the burst ends.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg   <= ARB_IDLE;
            rr_ptr_reg  <= '0;
            owner_reg   <= '0;
            cnt_reg     <= '0;
            sticky_reg  <= 1'b0;
            gnt_vld_reg <= 1'b0;
            req_rdy_reg <= '0;
`ifdef ADMA_ARB_TIMEOUT_EN
            busy_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
`endif
        end else begin
            req_rdy_reg <= '0;
`ifdef ADMA_ARB_TIMEOUT_EN
            timeout_reg <= 1'b0;
`endif
            case (state_reg)
                ARB_IDLE: begin
                    if (!sticky_hit) begin
                        sticky_reg <= 1'b0;
                    end
                    if (grant_any) begin
                        state_reg   <= ARB_BUSY;
                        req_rdy_reg <= rdy_onehot;
                        gnt_vld_reg <= 1'b1;
                        owner_reg   <= grant_id;
                        // A continuing owner keeps its remaining burst budget.
                        if (!sticky_hit) begin
                            cnt_reg <= chn_arb_rate_i[pick_win];
                        end
`ifdef ADMA_ARB_TIMEOUT_EN
                        busy_cnt_reg <= '0;
`endif
                    end
                end
                ARB_BUSY: begin
                    if (burst_done_i) begin
                        state_reg   <= ARB_IDLE;
                        gnt_vld_reg <= 1'b0;
                        if (cnt_reg == '0) begin
                            sticky_reg <= 1'b0;
                            rr_ptr_reg <= owner_next;
                        end else begin
                            cnt_reg    <= cnt_reg - 1'b1;
                            sticky_reg <= 1'b1;
                        end
                    end
`ifdef ADMA_ARB_TIMEOUT_EN
                    else if (busy_cnt_reg == TO_W'(ARB_TIMEOUT - 1)) begin
                        state_reg   <= ARB_IDLE;
                        gnt_vld_reg <= 1'b0;
                        timeout_reg <= 1'b1;
                        sticky_reg  <= 1'b0;
                        rr_ptr_reg  <= owner_next;
                    end else begin
                        busy_cnt_reg <= busy_cnt_reg + 1'b1;
                    end
`endif
                end
                default: state_reg <= ARB_IDLE;
            endcase
        end
    end

    assign req_rdy_o    = req_rdy_reg;
    assign gnt_vld_o    = gnt_vld_reg;
    assign gnt_chn_id_o = owner_reg;

`ifdef ADMA_ARB_TIMEOUT_EN
    assign arb_timeout_o = timeout_reg;
`else
    // No watchdog: ownership lasts until burst_done_i; output is constant 0.
    assign arb_timeout_o = (ARB_TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_adma_chn_arb.sv
// Directed bench for adma_chn_arb: a vector table of single-grant cases
// from reset, plus hand-written multi-burst sequences.
module tb_adma_chn_arb;

`ifdef ADMA_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic       dma_en = 1'b0;
    logic [3:0] chn_en = '0;
    logic [2:0] rate [0:3];
    logic [3:0] req_vld = '0;
    logic [3:0] req_rdy;
    logic       gnt_vld;
    logic [1:0] gnt_id;
    logic       burst_done = 1'b0;
    logic       arb_timeout;

    int n_total = 0;
    int n_pass  = 0;
    int seq_exp [10];

    always #5 aclk = ~aclk;

    adma_chn_arb #(
        .DMA_CHN_NUM   (4),
        .DMA_CHN_ARB_W (3),
        .ARB_TIMEOUT   (TO)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .dma_en_i       (dma_en),
        .chn_en_i       (chn_en),
        .chn_arb_rate_i (rate),
        .req_vld_i      (req_vld),
        .req_rdy_o      (req_rdy),
        .gnt_vld_o      (gnt_vld),
        .gnt_chn_id_o   (gnt_id),
        .burst_done_i   (burst_done),
        .arb_timeout_o  (arb_timeout)
    );

    typedef struct {
        logic       dma;
        logic [3:0] en;
        logic [3:0] req;
        logic       exp_vld;
        int         exp_id;
    } vec_t;

    vec_t tbl [8];

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp)
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic do_reset();
        areset     = 1'b1;
        burst_done = 1'b0;
        req_vld    = '0;
        tick();
        areset = 1'b0;
    endtask

    // Waits up to max cycles for a req_rdy_o pulse; id stays -1 on expiry.
    task automatic wait_grant(input int max, output int id, output int cyc);
        id  = -1;
        cyc = 0;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (req_rdy != 4'b0000) begin
                for (int k = 0; k < 4; k++)
                    if (req_rdy[k]) id = k;
                cyc = i;
                $display("grant ch%0d after %0d cycles (gnt_id=%0d)", id, cyc, gnt_id);
                return;
            end
        end
        $display("no grant within %0d cycles", max);
    endtask

    // Called in the first BUSY cycle; ends the burst after len cycles.
    task automatic run_burst(input int len);
        for (int i = 0; i < len - 1; i++) tick();
        burst_done = 1'b1;
        tick();
        burst_done = 1'b0;
        chk("gnt_drop_after_done", int'(gnt_vld), 0);
    endtask

    task automatic run_seq(input string name, input int n, input int len);
        int id, cyc;
        for (int i = 0; i < n; i++) begin
            wait_grant(10, id, cyc);
            chk(name, id, seq_exp[i]);
            if (id < 0) return;
            chk("gnt_id_match", int'(gnt_id), id);
            run_burst(len);
        end
    endtask

    initial begin
        int id, cyc, bad;
        tbl[0] = '{1'b1, 4'b1111, 4'b0001, 1'b1, 0};
        tbl[1] = '{1'b1, 4'b1111, 4'b0100, 1'b1, 2};
        tbl[2] = '{1'b1, 4'b1111, 4'b1010, 1'b1, 1};
        tbl[3] = '{1'b1, 4'b0111, 4'b1000, 1'b0, 0};
        tbl[4] = '{1'b0, 4'b1111, 4'b1111, 1'b0, 0};
        tbl[5] = '{1'b1, 4'b1101, 4'b0110, 1'b1, 2};
        tbl[6] = '{1'b1, 4'b1111, 4'b0000, 1'b0, 0};
        tbl[7] = '{1'b1, 4'b1000, 4'b1111, 1'b1, 3};
        for (int k = 0; k < 4; k++) rate[k] = 3'd0;

        // Reset state
        do_reset();
        chk("rst_gnt_vld", int'(gnt_vld), 0);
        chk("rst_req_rdy", int'(req_rdy), 0);
        chk("rst_gnt_id", int'(gnt_id), 0);
        chk("rst_timeout", int'(arb_timeout), 0);

        // Single-grant vectors from reset (search starts at rr_ptr=0)
        for (int v = 0; v < 8; v++) begin
            do_reset();
            dma_en  = tbl[v].dma;
            chn_en  = tbl[v].en;
            req_vld = tbl[v].req;
            tick();
            chk("vec_gnt_vld", int'(gnt_vld), int'(tbl[v].exp_vld));
            chk("vec_req_rdy", int'(req_rdy), tbl[v].exp_vld ? (1 << tbl[v].exp_id) : 0);
            if (tbl[v].exp_vld) begin
                chk("vec_gnt_id", int'(gnt_id), tbl[v].exp_id);
                req_vld = '0;
                run_burst(1);
            end
        end

        // Single channel, rate 0: latency, one-cycle rdy pulse, 2-cycle regrant
        do_reset();
        dma_en = 1'b1; chn_en = 4'b1111; req_vld = 4'b0001;
        wait_grant(4, id, cyc);
        chk("s1_id", id, 0);
        chk("s1_latency", cyc, 1);
        tick();
        chk("s1_rdy_pulse", int'(req_rdy), 0);
        chk("s1_vld_hold", int'(gnt_vld), 1);
        run_burst(2);
        for (int i = 0; i < 2; i++) begin
            wait_grant(4, id, cyc);
            chk("s1_regrant_id", id, 0);
            chk("s1_regrant_gap", cyc, 1);
            run_burst(3);
        end

        // Weighted: ch0 rate 2, ch1 rate 0
        do_reset();
        rate[0] = 3'd2; rate[1] = 3'd0;
        req_vld = 4'b0011;
        seq_exp = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
        run_seq("s2_weighted", 8, 4);

        // All four at rate 0, then ch2 drops out (wrap 3 -> 0)
        do_reset();
        for (int k = 0; k < 4; k++) rate[k] = 3'd0;
        req_vld = 4'b1111;
        seq_exp = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0};
        run_seq("s3_rr", 5, 2);
        req_vld = 4'b1011;
        seq_exp = '{1, 3, 0, 1, 3, 0, 0, 0, 0, 0};
        run_seq("s3_rr_drop", 5, 2);

        // Sticky owner ch1 (rate 3) stops requesting: search from owner+1
        do_reset();
        rate[0] = 3'd0; rate[1] = 3'd3; rate[2] = 3'd1; rate[3] = 3'd0;
        req_vld = 4'b0010;
        wait_grant(4, id, cyc);
        chk("s4_first", id, 1);
        req_vld = 4'b0101;
        run_burst(2);
        seq_exp = '{2, 2, 0, 0, 0, 0, 0, 0, 0, 0};
        run_seq("s4_after_drop", 3, 2);

        // burst_done_i in IDLE must not disturb the pointer
        do_reset();
        for (int k = 0; k < 4; k++) rate[k] = 3'd0;
        burst_done = 1'b1;
        tick();
        burst_done = 1'b0;
        chk("s5_idle_done_vld", int'(gnt_vld), 0);
        req_vld = 4'b0101;
        wait_grant(4, id, cyc);
        chk("s5_idle_done_id", id, 0);
        run_burst(1);

        // Mid-burst disable, global disable, reset mid-burst
        do_reset();
        req_vld = 4'b0011;
        wait_grant(4, id, cyc);
        chk("s6_first", id, 0);
        chn_en = 4'b1110;
        tick(); tick(); tick();
        chk("s6_hold_vld", int'(gnt_vld), 1);
        chk("s6_hold_id", int'(gnt_id), 0);
        run_burst(1);
        seq_exp = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        run_seq("s6_no_ch0", 3, 2);
        dma_en = 1'b0;
        wait_grant(10, id, cyc);
        chk("s6_dma_off_grant", id, -1);
        chk("s6_dma_off_vld", int'(gnt_vld), 0);
        dma_en = 1'b1;
        wait_grant(4, id, cyc);
        chk("s6_reenable", id, 1);
        tick();
        areset = 1'b1;
        tick();
        chk("s6_rst_vld", int'(gnt_vld), 0);
        chk("s6_rst_rdy", int'(req_rdy), 0);
        chk("s6_rst_id", int'(gnt_id), 0);
        chk("s6_rst_timeout", int'(arb_timeout), 0);
        areset = 1'b0;
        chn_en = 4'b1111;

        // Burst that never completes
        do_reset();
        req_vld = 4'b0011;
        wait_grant(4, id, cyc);
        chk("s7_first", id, 0);
`ifdef ADMA_ARB_TIMEOUT_EN
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (arb_timeout) begin
                cyc = i;
                break;
            end
        end
        chk("s7_timeout_cycle", cyc, 16);
        chk("s7_timeout_vld", int'(gnt_vld), 0);
        tick();
        chk("s7_timeout_pulse", int'(arb_timeout), 0);
        chk("s7_next_owner", int'(req_rdy), 4'b0010);
`else
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!gnt_vld || arb_timeout) bad++;
        end
        chk("s7_hold_100", bad, 0);
        run_burst(1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
